// File: rtl/spi_reg_port.sv
// spi_reg_port: SPI mode-0 slave bridging two-byte frames (command, data) onto a
// byte-wide peripheral register port. spi_clk edges are found by oversampling on clk.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   spi_cs_n       chip select (active low, pre-synchronized)
//   spi_clk        SPI clock (idle low, pre-synchronized)
//   spi_mosi       serial data in (pre-synchronized)
//   spi_miso       serial data out (registered)
//   reg_addr       peripheral register address
//   reg_data_i     peripheral read data
//   reg_data_o     peripheral write data
//   reg_data_o_dv  one-cycle write strobe
//   reg_rd         one-cycle read strobe
//
// Build option: define SPI_REG_AUTO_INC_EN to keep streaming bytes to successive
// addresses instead of ignoring everything after the first data byte.
module spi_reg_port #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] reg_data_o,
  output logic              reg_data_o_dv,
  output logic              reg_rd
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  if (DATA_W != 8) begin : g_data_w_check
    $error("spi_reg_port: DATA_W must be 8");
  end
  if (ADDR_W < 1 || ADDR_W > 7) begin : g_addr_w_check
    $error("spi_reg_port: ADDR_W must be in 1..7");
  end

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic                sclk_prev_q;
  logic                rw_q, rw_d;
  logic                miso_q, miso_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                dv_q, dv_d;
  logic                rd_q, rd_d;

  logic                rise_c;
  logic                fall_c;
  logic [BYTE_W-1:0]   byte_c;
  logic                last_bit_c;

  assign rise_c     = spi_clk & ~sclk_prev_q;
  assign fall_c     = ~spi_clk & sclk_prev_q;
  // Byte as it stands once the current mosi bit is shifted in.
  assign byte_c     = {rx_shift_q, spi_mosi};
  assign last_bit_c = (bit_cnt_q == CNT_W'(7));

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dv_d       = 1'b0;
    rd_d       = 1'b0;

    // Peripheral has seen the address for one cycle by now; capture its read data.
    if (rd_q) begin
      tx_shift_d = reg_data_i;
    end

    if (spi_cs_n) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end

        CMD: begin
          if (rise_c) begin
            rx_shift_d = byte_c[BYTE_W-2:0];
            bit_cnt_d  = CNT_W'(bit_cnt_q + CNT_W'(1));
            if (last_bit_c) begin
              rw_d    = byte_c[BYTE_W-1];
              addr_d  = ADDR_W'(byte_c);
              rd_d    = ~byte_c[BYTE_W-1];
              state_d = DATA;
            end
          end
        end

        DATA: begin
`ifdef SPI_REG_AUTO_INC_EN
          // Write address advances only after its strobe has gone out.
          if (dv_q) begin
            addr_d = ADDR_W'(addr_q + ADDR_W'(1));
          end
`endif
          if (fall_c && !rw_q) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
          if (rise_c) begin
            rx_shift_d = byte_c[BYTE_W-2:0];
            bit_cnt_d  = CNT_W'(bit_cnt_q + CNT_W'(1));
            if (last_bit_c) begin
              if (rw_q) begin
                wdata_d = DATA_W'(byte_c);
                dv_d    = 1'b1;
              end
`ifdef SPI_REG_AUTO_INC_EN
              if (!rw_q) begin
                addr_d = ADDR_W'(addr_q + ADDR_W'(1));
                rd_d   = 1'b1;
              end
`else
              state_d = HOLD;
              miso_d  = 1'b0;
`endif
            end
          end
        end

        HOLD: begin
          miso_d = 1'b0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      sclk_prev_q <= 1'b0;
      rw_q        <= 1'b0;
      miso_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dv_q        <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      sclk_prev_q <= spi_clk;
      rw_q        <= rw_d;
      miso_q      <= miso_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dv_q        <= dv_d;
      rd_q        <= rd_d;
    end
  end

  assign spi_miso      = miso_q;
  assign reg_addr      = addr_q;
  assign reg_data_o    = wdata_q;
  assign reg_data_o_dv = dv_q;
  assign reg_rd        = rd_q;

endmodule
